spi_master_rx: RTL and testbench

Receive datapath of the SPI master: samples MISO (single mode) or all four data lines (quad mode) on each `rx_edge` strobe from the clock generator. It assembles the bits MSB-first into 32-bit words and hands each word to the RX FIFO over a valid/ready handshake. When the FIFO back-pressures, it gates the SPI clock through `clk_en_o`. It is the receive counterpart of the TX datapath and shares its per-transfer bit-count programming.

---
 rtl/spi_master_rx.sv | 130 +++++++++++++
 tb/tb_spi_master_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_rx.sv
// rtl/spi_master_rx.sv - SPI master receive datapath: samples MISO or quad lines into 32-bit words
// Words leave over a valid/ready handshake; back-pressure stalls the SPI clock via clk_en_o.
module spi_master_rx (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        rx_edge,
    output logic        rx_done,
    output logic        clk_en_o,
    input  logic        sdi0,
    input  logic        sdi1,
    input  logic        sdi2,
    input  logic        sdi3,
    input  logic        en_quad_in,
    input  logic [15:0] counter_in,
    input  logic        counter_in_upd,
    output logic [31:0] data,
    output logic        data_valid,
    input  logic        data_ready
);

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        WAIT_FIFO,
        WAIT_FIFO_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_trgt;
    logic [31:0] r_sr;

    logic [15:0] w_trgt_m1;
    logic        w_last;
    logic        w_bnd;
    logic        w_word_done;
    logic [31:0] w_sr_n;

    // trgt of 0 wraps to 0xFFFF, giving a 65536-edge transfer
    assign w_trgt_m1   = r_trgt - 16'd1;
    assign w_last      = (r_cnt == w_trgt_m1);
    assign w_bnd       = en_quad_in ? (r_cnt[2:0] == 3'd7) : (r_cnt[4:0] == 5'd31);
    assign w_word_done = rx_edge && (r_state == RECEIVE) && (w_last || w_bnd);
    assign w_sr_n      = en_quad_in ? {r_sr[27:0], sdi3, sdi2, sdi1, sdi0}
                                    : {r_sr[30:0], sdi1};

    always_comb begin
        clk_en_o   = 1'b0;
        data_valid = 1'b0;
        data       = r_sr;
        rx_done    = 1'b0;
        unique case (r_state)
            IDLE: begin
                clk_en_o = en;
            end
            RECEIVE: begin
                clk_en_o = 1'b1;
                if (w_word_done) begin
                    data       = w_sr_n;
                    data_valid = 1'b1;
                    rx_done    = data_ready && w_last;
                end
            end
            WAIT_FIFO: begin
                data_valid = 1'b1;
            end
            WAIT_FIFO_DONE: begin
                data_valid = 1'b1;
                rx_done    = data_ready;
            end
            default: begin
                clk_en_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_trgt  <= 16'd8;
            r_sr    <= 32'd0;
        end else begin
            if (counter_in_upd) begin
                r_trgt <= en_quad_in ? {2'b00, counter_in[15:2]} : counter_in;
            end
            unique case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= RECEIVE;
                        r_sr    <= 32'd0;
                    end
                end
                RECEIVE: begin
                    if (rx_edge) begin
                        r_cnt <= w_last ? 16'd0 : r_cnt + 16'd1;
                        if (w_word_done && data_ready) begin
                            r_sr <= 32'd0;
                            if (w_last) begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_sr <= w_sr_n;
                            if (w_word_done) begin
                                r_state <= w_last ? WAIT_FIFO_DONE : WAIT_FIFO;
                            end
                        end
                    end
                end
                WAIT_FIFO: begin
                    if (data_ready) begin
                        r_state <= RECEIVE;
                        r_sr    <= 32'd0;
                    end
                end
                WAIT_FIFO_DONE: begin
                    if (data_ready) begin
                        r_state <= IDLE;
                        r_sr    <= 32'd0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_rx.sv
// tb/tb_spi_master_rx.sv - scoreboard bench for spi_master_rx
// Driver pushes expected words; a negedge monitor checks every presented word and rx_done.
module tb_spi_master_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        rx_edge = 1'b0;
    logic        rx_done;
    logic        clk_en_o;
    logic        sdi0 = 1'b0;
    logic        sdi1 = 1'b0;
    logic        sdi2 = 1'b0;
    logic        sdi3 = 1'b0;
    logic        en_quad_in = 1'b0;
    logic [15:0] counter_in = 16'd0;
    logic        counter_in_upd = 1'b0;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready = 1'b1;

    typedef struct {
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    spi_master_rx dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .rx_edge        (rx_edge),
        .rx_done        (rx_done),
        .clk_en_o       (clk_en_o),
        .sdi0           (sdi0),
        .sdi1           (sdi1),
        .sdi2           (sdi2),
        .sdi3           (sdi3),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic l);
        exp_t e;
        e.w = w;
        e.l = l;
        q.push_back(e);
    endtask

    task automatic edge_once(input logic [3:0] nib, input logic rdy);
        {sdi3, sdi2, sdi1, sdi0} = nib;
        data_ready = rdy;
        rx_edge    = 1'b1;
        tick();
        rx_edge    = 1'b0;
    endtask

    // single mode: sdi1 carries the bit, other lines get noise that must be ignored
    task automatic send_bits(input logic [31:0] w, input int n, input logic rdy_last);
        for (int i = n - 1; i >= 0; i--) begin
            edge_once({w[i], 1'b1, w[i], ~w[i]}, (i == 0) ? rdy_last : 1'b1);
            if (i != 0) tick();
        end
    endtask

    task automatic send_nibs(input logic [31:0] w, input int n, input logic rdy_last);
        for (int i = n - 1; i >= 0; i--) begin
            edge_once(w[i*4 +: 4], (i == 0) ? rdy_last : 1'b1);
            if (i != 0) tick();
        end
    endtask

    task automatic start(input logic [15:0] len, input logic quad, input logic upd);
        en_quad_in = quad;
        if (upd) begin
            counter_in     = len;
            counter_in_upd = 1'b1;
            tick();
            counter_in_upd = 1'b0;
        end
        en = 1'b1;
        #1;
        chk("idle_clk_en_follows_en", {31'd0, clk_en_o}, 32'd1);
        tick();
        en = 1'b0;
        tick();
    endtask

    task automatic check_idle(input string nm);
        tick();
        chk({nm, "_clk_en"}, {31'd0, clk_en_o}, 32'd0);
        chk({nm, "_data"}, data, 32'd0);
    endtask

    // monitor: every cycle a word is presented it must match the scoreboard head
    always @(negedge clk) begin
        if (data_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word got %h want none", data);
            end else begin
                chk("word", data, q[0].w);
                if (data_ready) begin
                    chk("rx_done_on_accept", {31'd0, rx_done}, {31'd0, q[0].l});
                    void'(q.pop_front());
                end
            end
        end
        if (rx_done && !(data_valid && data_ready)) begin
            checks++;
            errors++;
            $display("FAIL rx_done_without_handshake got 1 want 0");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_rx_done", {31'd0, rx_done}, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en_o}, 32'd0);
        chk("rst_data", data, 32'd0);
        rstn = 1'b1;
        tick();

        // single 8 bits
        start(16'd8, 1'b0, 1'b1);
        push(32'h0000_00A5, 1'b1);
        send_bits(32'h0000_00A5, 8, 1'b1);
        check_idle("t1_idle");

        // quad 32 bits
        start(16'd32, 1'b1, 1'b1);
        push(32'hDEAD_BEEF, 1'b1);
        send_nibs(32'hDEAD_BEEF, 8, 1'b1);
        check_idle("t2_idle");

        // quad with counter_in[1:0] discarded: 14 -> 3 edges
        start(16'd14, 1'b1, 1'b1);
        push(32'h0000_0123, 1'b1);
        send_nibs(32'h0000_0123, 3, 1'b1);
        check_idle("t2b_idle");

        // single 64 bits, back-pressure on word 1, stray edge ignored while waiting
        start(16'd64, 1'b0, 1'b1);
        push(32'h1234_5678, 1'b0);
        push(32'h9ABC_DEF0, 1'b1);
        send_bits(32'h1234_5678, 32, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("t3_wait_clk_en", {31'd0, clk_en_o}, 32'd0);
            chk("t3_wait_valid", {31'd0, data_valid}, 32'd1);
            rx_edge = (c == 2);
            sdi1    = 1'b1;
            tick();
        end
        rx_edge    = 1'b0;
        data_ready = 1'b1;
        tick();
        chk("t3_resume_clk_en", {31'd0, clk_en_o}, 32'd1);
        tick();
        send_bits(32'h9ABC_DEF0, 32, 1'b1);
        check_idle("t3_idle");

        // single 40 bits, partial final word held in WAIT_FIFO_DONE
        start(16'd40, 1'b0, 1'b1);
        push(32'hCAFE_F00D, 1'b0);
        push(32'h0000_003C, 1'b1);
        send_bits(32'hCAFE_F00D, 32, 1'b1);
        tick();
        data_ready = 1'b0;
        send_bits(32'h0000_003C, 8, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("t4_wait_clk_en", {31'd0, clk_en_o}, 32'd0);
            chk("t4_wait_rx_done", {31'd0, rx_done}, 32'd0);
            tick();
        end
        data_ready = 1'b1;
        tick();
        chk("t4_after_done_clk_en", {31'd0, clk_en_o}, 32'd0);
        check_idle("t4_idle");

        // reset after 13 edges of a 32-bit transfer, then default trgt=8
        start(16'd32, 1'b0, 1'b1);
        send_bits(32'h0000_1FFF, 13, 1'b1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, data_valid}, 32'd0);
        chk("t5_rst_rx_done", {31'd0, rx_done}, 32'd0);
        chk("t5_rst_clk_en", {31'd0, clk_en_o}, 32'd0);
        chk("t5_rst_data", data, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        start(16'd0, 1'b0, 1'b0);
        push(32'h0000_005A, 1'b1);
        send_bits(32'h0000_005A, 8, 1'b1);
        check_idle("t5_idle");

        // idle: edges with en=0 must not shift or count
        for (int c = 0; c < 10; c++) begin
            edge_once(4'hF, 1'b1);
            chk("t6_idle_clk_en", {31'd0, clk_en_o}, 32'd0);
            chk("t6_idle_valid", {31'd0, data_valid}, 32'd0);
        end
        chk("t6_idle_data", data, 32'd0);
        start(16'd0, 1'b0, 1'b0);
        push(32'h0000_00C3, 1'b1);
        send_bits(32'h0000_00C3, 8, 1'b1);
        check_idle("t6_idle_end");

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
